serial_eq_arbiter: RTL and testbench

Controller that shares one external 1-bit equivalence cell (F = A XNOR B) between two requesters and runs a bit-serial W-bit equality compare on it. Each requester presents two W-bit operands. The block grants one requester round-robin and streams the operand bits LSB-first through the cell over W cycles, ANDing the cell outputs. It then returns a registered equal/not-equal result with a one-cycle done pulse. It sits between the requesting logic and the single combinational equivalence cell in the lab datapath.

---
 rtl/serial_eq_arbiter.sv | 138 +++++++++++++
 tb/tb_serial_eq_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_eq_arbiter.sv
// Round-robin arbiter sharing one external XNOR cell between two requesters,
// running a bit-serial LSB-first W-bit equality compare and returning eq with a done pulse.
module serial_eq_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         owner,
  output logic         xa,
  output logic         xb,
  input  logic         xf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          eq_q, eq_d;
  logic          done_q, done_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;

  // last_owner resets to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b1;
      eq_q         <= 1'b0;
      done_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      eq_q         <= eq_d;
      done_q       <= done_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
    end
  end

  always_comb begin
    logic winner;
    winner       = 1'b0;
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    eq_d         = eq_q;
    done_d       = 1'b0;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    xa           = 1'b0;
    xb           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On contention the requester that did not win last time goes next.
          winner       = (req0 && req1) ? ~last_owner_q : req1;
          a_sh_d       = winner ? a1 : a0;
          b_sh_d       = winner ? b1 : b0;
          cnt_d        = '0;
          acc_d        = 1'b1;
          owner_d      = winner;
          last_owner_d = winner;
          gnt0_d       = ~winner;
          gnt1_d       = winner;
          state_d      = S_COMPARE;
        end
      end
      S_COMPARE: begin
        xa     = a_sh_q[0];
        xb     = b_sh_q[0];
        acc_d  = acc_q & xf;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // All W bits are always visited; a mismatch does not end the compare early.
        if (cnt_q == CNT_LAST) begin
          eq_d    = acc_q & xf;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign eq    = eq_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_serial_eq_arbiter.sv
// Directed bench for serial_eq_arbiter: a W=4 instance and a W=1 instance, each
// driving a modelled XNOR cell; expected values are hand-computed per cycle.
module tb_serial_eq_arbiter;

  logic       clk = 1'b0;
  logic       reset;

  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, done, eq, owner, xa, xb, xf;

  logic       w1Req0, w1Req1;
  logic [0:0] w1A0, w1B0, w1A1, w1B1;
  logic       w1Gnt0, w1Gnt1, w1Busy, w1Done, w1Eq, w1Owner, w1Xa, w1Xb, w1Xf;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  assign xf   = ~(xa ^ xb);
  assign w1Xf = ~(w1Xa ^ w1Xb);

  serial_eq_arbiter #(.W(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .eq(eq), .owner(owner), .xa(xa), .xb(xb), .xf(xf)
  );

  serial_eq_arbiter #(.W(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0(w1Req0), .a0(w1A0), .b0(w1B0),
    .req1(w1Req1), .a1(w1A1), .b1(w1B1),
    .gnt0(w1Gnt0), .gnt1(w1Gnt1), .busy(w1Busy), .done(w1Done),
    .eq(w1Eq), .owner(w1Owner), .xa(w1Xa), .xb(w1Xb), .xf(w1Xf)
  );

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] expA, expB;
    logic [2:0] expVec;
    logic       expEq;

    reset = 1'b1;
    req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    w1Req0 = 0; w1Req1 = 0; w1A0 = 0; w1B0 = 0; w1A1 = 0; w1B1 = 0;
    applyStimulus(2);
    reset = 1'b0;
    checkOutput("reset_outputs", {gnt0, gnt1, busy, done, eq, owner, xa, xb}, 8'h00);

    // Equal operands 1010/1010.
    req0 = 1; a0 = 4'b1010; b0 = 4'b1010;
    expA = 4'b1010; expB = 4'b1010;
    applyStimulus(1);
    checkOutput("t1_gnt", {gnt0, gnt1, busy}, 8'b101);
    req0 = 0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_bit%0d", i), {xa, xb}, {6'd0, expA[i], expB[i]});
      applyStimulus(1);
    end
    checkOutput("t1_done", {done, eq, owner, busy}, 8'b1101);
    applyStimulus(1);
    checkOutput("t1_idle", {busy, done}, 8'b00);

    // MSB-only mismatch.
    req0 = 1; a0 = 4'b1000; b0 = 4'b0000;
    applyStimulus(1);
    checkOutput("t2_gnt", gnt0, 1);
    req0 = 0;
    applyStimulus(3);
    checkOutput("t2_msb_bit", {done, xa, xb}, 8'b010);
    applyStimulus(1);
    checkOutput("t2_done", {done, eq, owner}, 8'b100);
    applyStimulus(1);

    // Both requests held through reset, then continuously.
    reset = 1; req0 = 1; req1 = 1; a0 = 0; b0 = 0; a1 = 4'h5; b1 = 4'h5;
    applyStimulus(1);
    checkOutput("t3_reset_nogrant", {gnt0, gnt1}, 8'b00);
    reset = 0;
    for (int c = 1; c <= 17; c++) begin
      applyStimulus(1);
      expVec = {(c == 1 || c == 13), (c == 7), (c == 5 || c == 11 || c == 17)};
      checkOutput($sformatf("t3_cyc%0d", c), {gnt0, gnt1, done}, {5'd0, expVec});
      if (c == 5 || c == 11 || c == 17)
        checkOutput($sformatf("t3_owner%0d", c), owner, (c == 11) ? 8'd1 : 8'd0);
    end
    req0 = 0; req1 = 0;
    applyStimulus(1);

    // req1 arrives mid-compare and must wait for IDLE; eq holds between dones.
    req0 = 1; a0 = 4'b0011; b0 = 4'b0001;
    applyStimulus(1);
    checkOutput("t4_gnt0", gnt0, 1);
    req0 = 0;
    req1 = 1; a1 = 4'hF; b1 = 4'hF;
    for (int r = 2; r <= 11; r++) begin
      applyStimulus(1);
      expVec = {1'b0, (r == 7), (r == 5 || r == 11)};
      expEq  = (r < 5) ? 1'b1 : ((r < 11) ? 1'b0 : 1'b1);
      checkOutput($sformatf("t4_rel%0d", r), {gnt0, gnt1, done, eq}, {4'd0, expVec, expEq});
      if (r == 5 || r == 11)
        checkOutput($sformatf("t4_owner%0d", r), owner, (r == 11) ? 8'd1 : 8'd0);
      if (gnt1) req1 = 0;
    end
    applyStimulus(1);

    // Reset in the second compare cycle aborts without a done.
    req0 = 1; a0 = 4'hF; b0 = 4'hF;
    applyStimulus(1);
    req0 = 0;
    applyStimulus(1);
    checkOutput("t5_mid_compare", {busy, xa, xb}, 8'b111);
    reset = 1;
    applyStimulus(1);
    reset = 0;
    checkOutput("t5_after_reset", {busy, done, eq, owner, xa, xb, gnt0}, 8'h00);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("t5_nodone%0d", k), {busy, done}, 8'b00);
    end
    req0 = 1; req1 = 1;
    applyStimulus(1);
    checkOutput("t5_rr_restart", {gnt0, gnt1}, 8'b10);
    req0 = 0; req1 = 0;
    applyStimulus(6);

    // W=1 instance.
    w1Req0 = 1; w1A0 = 1'b1; w1B0 = 1'b0;
    applyStimulus(1);
    checkOutput("w1_gnt_a", {w1Gnt0, w1Busy, w1Xa, w1Xb}, 8'b1110);
    w1Req0 = 0;
    applyStimulus(1);
    checkOutput("w1_done_a", {w1Done, w1Eq, w1Owner}, 8'b100);
    applyStimulus(1);
    w1Req0 = 1; w1A0 = 1'b1; w1B0 = 1'b1;
    applyStimulus(1);
    checkOutput("w1_gnt_b", w1Gnt0, 1);
    w1Req0 = 0;
    applyStimulus(1);
    checkOutput("w1_done_b", {w1Done, w1Eq, w1Owner}, 8'b110);
    applyStimulus(1);
    checkOutput("w1_idle", {w1Busy, w1Done}, 8'b00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
